// File: rtl/cram_addr_seq.sv
// cram_addr_seq: registered control-RAM next-address sequencer with a return-address stack.
// Stack overflow/underflow trapping is enabled by defining CRAM_ADDR_SEQ_STACK_CHECK_EN.
module cram_addr_seq #(
    parameter int unsigned STACK_DEPTH = 16,
    parameter logic [11:0] TRAP_ADDR   = 12'o7777
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [10:0]                   j,
    input  logic [5:0]                    skip,
    input  logic [7:0]                    cond,
    input  logic                          call,
    input  logic [4:0]                    disp,
    input  logic [3:0]                    disp_data,
    input  logic [11:0]                   dram_addr,
    input  logic                          hold,
    input  logic                          force_en,
    input  logic [11:0]                   force_addr,
    output logic [11:0]                   cradr,
    output logic                          stack_err,
    output logic [$clog2(STACK_DEPTH):0]  sp
);
    localparam int unsigned AW = $clog2(STACK_DEPTH);
    localparam logic [AW:0]   SP_FULL = (AW+1)'(STACK_DEPTH);
    localparam logic [AW:0]   SP_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [11:0]   stack_mem [STACK_DEPTH];
    logic [AW-1:0] wptr, wptr_n, wr_idx;
    logic [AW:0]   sp_n;
    logic [11:0]   base, nxt, popped, cradr_n;
    logic          is_ret, underflow, overflow, push_we;
    logic          skip_unused;

    assign skip_unused = skip[4];

    // The stack is a circular buffer: wptr wraps independently of sp so an
    // unchecked overflow overwrites the oldest entry while the newest stays on top.
    always_comb begin
        base      = {1'b0, j};
        is_ret    = (disp == 5'b00001);
        popped    = stack_mem[wptr - PTR_ONE];
        underflow = is_ret && (sp == '0);
        overflow  = 1'b0;
        push_we   = 1'b0;
        sp_n      = sp;
        wptr_n    = wptr;
        wr_idx    = wptr;

        if (is_ret)
            nxt = underflow ? base : (popped | {8'b0, j[3:0]});
        else if (disp == 5'b00010)
            nxt = dram_addr;
        else if (disp[4])
            nxt = base | {8'b0, disp_data};
        else
            nxt = base;

        if (skip[5] && (cond[skip[2:0]] ^ skip[3]))
            nxt[0] = 1'b1;

        // Pop before push so CALL+RETURN replaces the top entry in place.
        if (is_ret && !underflow) begin
            sp_n   = sp - SP_ONE;
            wptr_n = wptr - PTR_ONE;
        end

        if (call) begin
            wr_idx   = wptr_n;
            overflow = (sp_n == SP_FULL);
`ifdef CRAM_ADDR_SEQ_STACK_CHECK_EN
            push_we  = !overflow;
`else
            push_we  = 1'b1;
`endif
            if (push_we) begin
                wptr_n = wptr_n + PTR_ONE;
                if (!overflow)
                    sp_n = sp_n + SP_ONE;
            end
        end

        cradr_n = nxt;
`ifdef CRAM_ADDR_SEQ_STACK_CHECK_EN
        if (overflow || underflow)
            cradr_n = TRAP_ADDR;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cradr <= '0;
            sp    <= '0;
            wptr  <= '0;
        end else if (force_en) begin
            cradr <= force_addr;
            sp    <= '0;
            wptr  <= '0;
        end else if (!hold) begin
            cradr <= cradr_n;
            sp    <= sp_n;
            wptr  <= wptr_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && !force_en && !hold && push_we)
            stack_mem[wr_idx] <= cradr + 12'd1;
    end

`ifdef CRAM_ADDR_SEQ_STACK_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stack_err <= 1'b0;
        else if (force_en)
            stack_err <= 1'b0;
        else if (!hold && (overflow || underflow))
            stack_err <= 1'b1;
    end
`else
    localparam logic [11:0] TRAP_ADDR_unused = TRAP_ADDR;
    assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_cram_addr_seq.sv
// Scoreboard bench for cram_addr_seq: queue-based return-stack reference model,
// directed cases followed by randomized microword fields.
module tb_cram_addr_seq;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned SPW   = $clog2(DEPTH) + 1;
`ifdef CRAM_ADDR_SEQ_STACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic [10:0]     j;
    logic [5:0]      skip;
    logic [7:0]      cond;
    logic            call;
    logic [4:0]      disp;
    logic [3:0]      disp_data;
    logic [11:0]     dram_addr;
    logic            hold;
    logic            force_en;
    logic [11:0]     force_addr;
    logic [11:0]     cradr;
    logic            stack_err;
    logic [SPW-1:0]  sp;

    cram_addr_seq #(.STACK_DEPTH(DEPTH), .TRAP_ADDR(12'o7777)) dut (
        .clk(clk), .reset_n(reset_n), .j(j), .skip(skip), .cond(cond), .call(call),
        .disp(disp), .disp_data(disp_data), .dram_addr(dram_addr), .hold(hold),
        .force_en(force_en), .force_addr(force_addr), .cradr(cradr),
        .stack_err(stack_err), .sp(sp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] j;
        logic [5:0]  skip;
        logic [7:0]  cond;
        logic        call;
        logic [4:0]  disp;
        logic [3:0]  dd;
        logic [11:0] dram;
        logic        hold;
        logic        fe;
        logic [11:0] fa;
    } fields_t;

    typedef struct packed {
        logic [11:0]    cr;
        logic [SPW-1:0] sp;
        logic           err;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] ret_stk[$];
    logic [11:0] m_cr;
    logic        m_err;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0o want %0o", name, act, req);
        end
    endtask

    function automatic fields_t idle();
        fields_t f;
        f = '0;
        return f;
    endfunction

    function automatic fields_t rand_fields();
        fields_t f;
        int r;
        f.j    = 11'($urandom);
        f.skip = 6'($urandom);
        f.cond = 8'($urandom);
        f.call = ($urandom_range(0, 9) < 3);
        r = $urandom_range(0, 9);
        if (r < 3)       f.disp = 5'b00001;
        else if (r == 3) f.disp = 5'b00010;
        else if (r < 6)  f.disp = {1'b1, 4'($urandom)};
        else             f.disp = 5'($urandom);
        f.dd   = 4'($urandom);
        f.dram = 12'($urandom);
        f.hold = ($urandom_range(0, 9) == 0);
        f.fe   = ($urandom_range(0, 39) == 0);
        f.fa   = 12'($urandom);
        return f;
    endfunction

    // Drive fields now and record what the next rising edge must produce.
    task automatic apply(input fields_t f);
        logic [11:0] base, nxt, ret_addr;
        bit trap;
        j = f.j; skip = f.skip; cond = f.cond; call = f.call; disp = f.disp;
        disp_data = f.dd; dram_addr = f.dram; hold = f.hold;
        force_en = f.fe; force_addr = f.fa;
        if (f.fe) begin
            m_cr = f.fa;
            ret_stk.delete();
            if (CHK) m_err = 1'b0;
        end else if (!f.hold) begin
            trap     = 1'b0;
            base     = {1'b0, f.j};
            ret_addr = m_cr + 12'd1;
            if (f.disp == 5'd1) begin
                if (ret_stk.size() == 0) begin
                    nxt  = base;
                    trap = CHK;
                end else begin
                    nxt = ret_stk.pop_back() | {8'b0, f.j[3:0]};
                end
            end else if (f.disp == 5'd2) nxt = f.dram;
            else if (f.disp[4])        nxt = base | {8'b0, f.dd};
            else                       nxt = base;
            if (f.skip[5] && (f.cond[f.skip[2:0]] ^ f.skip[3])) nxt[0] = 1'b1;
            if (f.call) begin
                if (ret_stk.size() == DEPTH) begin
                    if (CHK) trap = 1'b1;
                    else begin
                        void'(ret_stk.pop_front());
                        ret_stk.push_back(ret_addr);
                    end
                end else begin
                    ret_stk.push_back(ret_addr);
                end
            end
            if (trap) begin
                m_cr  = 12'o7777;
                m_err = 1'b1;
            end else begin
                m_cr = nxt;
            end
        end
        exp_q.push_back('{m_cr, SPW'(ret_stk.size()), m_err});
    endtask

    task automatic issue(input fields_t f);
        @(negedge clk);
        apply(f);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cradr", 32'(cradr), 32'(e.cr));
            check("sp", 32'(sp), 32'(e.sp));
            check("stack_err", 32'(stack_err), 32'(e.err));
        end
    end

    initial begin
        fields_t f;
        apply_idle_inputs();
        m_cr = '0; m_err = 1'b0;
        #2 reset_n = 1'b0;
        #2;
        check("reset_cradr", 32'(cradr), 32'o0);
        check("reset_sp", 32'(sp), 0);
        check("reset_err", 32'(stack_err), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        f = idle(); f.j = 11'o0100;
        apply(f);

        f = idle(); f.j = 11'o0200; f.skip = 6'b100011; f.cond = 8'h08; issue(f);
        f.cond = 8'h00; issue(f);
        f.skip = 6'b101011; issue(f);

        f = idle(); f.fe = 1'b1; f.fa = 12'o0500; issue(f);
        f = idle(); f.call = 1'b1; f.j = 11'o1000; issue(f);
        f = idle(); f.disp = 5'b00001; f.j = 11'o0003; issue(f);

        f = idle(); f.disp = 5'b10000; f.j = 11'o0740; f.dd = 4'hA; issue(f);
        f = idle(); f.disp = 5'b00010; f.dram = 12'o3456; issue(f);

        f = idle(); f.fe = 1'b1; issue(f);
        for (int i = 0; i < 17; i++) begin
            f = idle(); f.call = 1'b1; f.j = 11'($urandom); issue(f);
        end
        f = idle(); f.call = 1'b1; f.disp = 5'b00001; f.j = 11'o0017; issue(f);
        for (int i = 0; i < 18; i++) begin
            f = idle(); f.disp = 5'b00001; f.j = 11'($urandom); issue(f);
        end
        f = idle(); f.fe = 1'b1; issue(f);
        f = idle(); f.disp = 5'b00001; f.j = 11'o0123; issue(f);

        f = idle(); f.call = 1'b1; f.j = 11'o0400; issue(f);
        for (int i = 0; i < 3; i++) begin
            f = rand_fields(); f.hold = 1'b1; f.fe = 1'b0; issue(f);
        end
        f = rand_fields(); f.hold = 1'b1; f.fe = 1'b1; f.fa = 12'o1234; issue(f);

        // Reset in the middle of a pending push/pop.
        f = idle(); f.call = 1'b1; f.j = 11'o0600; issue(f);
        @(negedge clk);
        j = 11'o0700; call = 1'b1; disp = 5'b00001; hold = 1'b0; force_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("midreset_cradr", 32'(cradr), 32'o0);
        check("midreset_sp", 32'(sp), 0);
        @(negedge clk);
        check("midreset_hold_cradr", 32'(cradr), 32'o0);
        reset_n = 1'b1;
        m_cr = '0; m_err = 1'b0; ret_stk.delete();
        f = idle(); f.call = 1'b1; f.j = 11'o0055; apply(f);

        for (int i = 0; i < 600; i++) issue(rand_fields());

        issue(idle());
        @(posedge clk);
        @(posedge clk);
        #2;
        check("drain", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic apply_idle_inputs();
        j = '0; skip = '0; cond = '0; call = 1'b0; disp = '0; disp_data = '0;
        dram_addr = '0; hold = 1'b0; force_en = 1'b0; force_addr = '0;
    endtask

endmodule
